// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input front-end: PS/2 scancodes, joystick
// bit positions (which depend on the number of fire buttons) and coin FSM states.
package arcade_input_pkg;

  localparam logic [7:0] ScStart1  = 8'h16;
  localparam logic [7:0] ScStart2  = 8'h1E;
  localparam logic [7:0] ScCoin1   = 8'h2E;
  localparam logic [7:0] ScCoin2   = 8'h36;
  localparam logic [7:0] ScService = 8'h46;
  localparam logic [7:0] ScPause   = 8'h4D;
  localparam logic [7:0] ScUp      = 8'h75;
  localparam logic [7:0] ScDown    = 8'h72;
  localparam logic [7:0] ScLeft    = 8'h6B;
  localparam logic [7:0] ScRight   = 8'h74;
  localparam logic [7:0] ScBtn0    = 8'h14;
  localparam logic [7:0] ScBtn1    = 8'h11;
  localparam logic [7:0] ScBtn2    = 8'h29;
  localparam logic [7:0] ScBtn3    = 8'h12;

  localparam int unsigned JoyRight    = 0;
  localparam int unsigned JoyLeft     = 1;
  localparam int unsigned JoyDown     = 2;
  localparam int unsigned JoyUp       = 3;
  localparam int unsigned JoyAutofire = 15;

  function automatic int unsigned joy_btn(input int unsigned k);
    return 4 + k;
  endfunction

  function automatic int unsigned joy_start1(input int unsigned nb);
    return 4 + nb;
  endfunction

  function automatic int unsigned joy_coin1(input int unsigned nb);
    return 5 + nb;
  endfunction

  function automatic int unsigned joy_start2(input int unsigned nb);
    return 6 + nb;
  endfunction

  function automatic int unsigned joy_pause(input int unsigned nb);
    return 7 + nb;
  endfunction

  // Keyboard key latches, one bit per mapped key.
  typedef struct packed {
    logic       start1;
    logic       start2;
    logic       coin1;
    logic       coin2;
    logic       service;
    logic       pause;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [3:0] btn;
  } key_state_t;

  typedef enum logic [1:0] {StIdle, StPulse, StHold} coin_state_e;

endpackage

// File: rtl/arcade_input_ctrl_coin_pulse_shaper.sv
// Coin pulse shaper: one fixed-length active-low pulse per rising edge of the
// coin input, then waits for release before re-arming.
module coin_pulse_shaper #(
  parameter int unsigned COIN_PULSE_CYCLES = 4915200
) (
  input  logic clk_49m,
  input  logic reset,
  input  logic coin,
  output logic coin_n
);
  import arcade_input_pkg::*;

  localparam int unsigned CntW = $clog2(COIN_PULSE_CYCLES + 1);

  coin_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            coin_prev_q;
  logic            coin_n_d;

  // State, counter, edge history and registered output.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      coin_prev_q <= 1'b0;
      coin_n      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coin_prev_q <= coin;
      coin_n      <= coin_n_d;
    end
  end

  // Next state: the load edge plus COIN_PULSE_CYCLES-1 countdown edges keep coin_n low.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    coin_n_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (coin && !coin_prev_q) begin
          state_d  = StPulse;
          cnt_d    = CntW'(COIN_PULSE_CYCLES - 1);
          coin_n_d = 1'b0;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = coin ? StHold : StIdle;
        end else begin
          cnt_d    = cnt_q - CntW'(1);
          coin_n_d = 1'b0;
        end
      end
      StHold: begin
        if (!coin) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input front-end: merges PS/2 keys and joysticks, shapes coins,
// edge-detects pause and captures DIP banks from ioctl index 254.
// Optional feature macro: ARCADE_INPUT_AUTOFIRE_EN (autofire on button 0).
module arcade_input_ctrl #(
  parameter int unsigned NUM_PLAYERS       = 2,
  parameter int unsigned NUM_BUTTONS       = 2,
  parameter int unsigned NUM_DIP_BANKS     = 3,
  parameter int unsigned COIN_PULSE_CYCLES = 4915200,
  parameter int unsigned AUTOFIRE_DIV      = 1638400
) (
  input  logic                                clk_49m,
  input  logic                                reset,
  input  logic [10:0]                         ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]           joy_in,
  input  logic                                ioctl_wr,
  input  logic [7:0]                          ioctl_index,
  input  logic [24:0]                         ioctl_addr,
  input  logic [7:0]                          ioctl_dout,
  output logic [4*NUM_PLAYERS-1:0]            dir_n,
  output logic [NUM_BUTTONS*NUM_PLAYERS-1:0]  btn_n,
  output logic [1:0]                          start_n,
  output logic [1:0]                          coin_n,
  output logic                                service_n,
  output logic                                pause_pulse,
  output logic [8*NUM_DIP_BANKS-1:0]          dipsw_n
);
  import arcade_input_pkg::*;

  logic                                toggle_q;
  key_state_t                          key_q, key_d;
  logic [4*NUM_PLAYERS-1:0]            dir_m;
  logic [NUM_BUTTONS*NUM_PLAYERS-1:0]  btn_m;
  logic                                start1_m, start2_m, coin1_m, pause_m;
  logic                                pause_prev_q;
  logic [15:0]                         joy_p;
  logic [NUM_PLAYERS-1:0]              af_wave;
  logic [NUM_DIP_BANKS-1:0][7:0]       bank_q;

  // Wide inputs are only partly decoded (spare joystick bits, key bit 8, unused buttons).
  logic unused_in;
  assign unused_in = ^{joy_in, ps2_key, key_q};

  // Keyboard toggle history and key latches.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      toggle_q <= 1'b0;
      key_q    <= '0;
    end else begin
      toggle_q <= ps2_key[10];
      key_q    <= key_d;
    end
  end

  // A toggle change updates the latch of the reported scancode only.
  always_comb begin
    key_d = key_q;
    if (ps2_key[10] != toggle_q) begin
      case (ps2_key[7:0])
        ScStart1:  key_d.start1  = ps2_key[9];
        ScStart2:  key_d.start2  = ps2_key[9];
        ScCoin1:   key_d.coin1   = ps2_key[9];
        ScCoin2:   key_d.coin2   = ps2_key[9];
        ScService: key_d.service = ps2_key[9];
        ScPause:   key_d.pause   = ps2_key[9];
        ScUp:      key_d.up      = ps2_key[9];
        ScDown:    key_d.down    = ps2_key[9];
        ScLeft:    key_d.left    = ps2_key[9];
        ScRight:   key_d.right   = ps2_key[9];
        ScBtn0:    key_d.btn[0]  = ps2_key[9];
        ScBtn1:    key_d.btn[1]  = ps2_key[9];
        ScBtn2:    key_d.btn[2]  = ps2_key[9];
        ScBtn3:    key_d.btn[3]  = ps2_key[9];
        default: ;
      endcase
    end
  end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int unsigned AfW = $clog2(AUTOFIRE_DIV + 1);

  logic [AfW-1:0]         af_cnt_q;
  logic                   af_tick;
  logic [NUM_PLAYERS-1:0] af_hold_q, af_phase_q, af_phase_d, af_rise;

  assign af_tick = (af_cnt_q == AfW'(AUTOFIRE_DIV - 1));

  // Shared free-running half-period counter plus per-player phase and hold history.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      af_cnt_q   <= '0;
      af_hold_q  <= '0;
      af_phase_q <= '0;
    end else begin
      af_cnt_q   <= af_tick ? '0 : af_cnt_q + AfW'(1);
      af_phase_q <= af_phase_d;
      for (int p = 0; p < NUM_PLAYERS; p++) af_hold_q[p] <= joy_in[16*p+JoyAutofire];
    end
  end

  // Phase restarts high on the hold edge so the first shot fires immediately.
  always_comb begin
    af_rise    = '0;
    af_phase_d = af_phase_q;
    af_wave    = '1;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      af_rise[p] = joy_in[16*p+JoyAutofire] & ~af_hold_q[p];
      if (af_rise[p])   af_phase_d[p] = 1'b1;
      else if (af_tick) af_phase_d[p] = ~af_phase_q[p];
      af_wave[p] = ~joy_in[16*p+JoyAutofire] | af_rise[p] | af_phase_q[p];
    end
  end
`else
  localparam int unsigned unused_af_div = AUTOFIRE_DIV;
  assign af_wave = '1;
`endif

  // Merge keyboard latches into every player and OR the shared controls over players.
  always_comb begin
    dir_m    = '0;
    btn_m    = '0;
    joy_p    = '0;
    start1_m = key_q.start1;
    start2_m = key_q.start2;
    coin1_m  = key_q.coin1;
    pause_m  = key_q.pause;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      joy_p        = joy_in[16*p +: 16];
      dir_m[4*p+0] = joy_p[JoyLeft]  | key_q.left;
      dir_m[4*p+1] = joy_p[JoyRight] | key_q.right;
      dir_m[4*p+2] = joy_p[JoyUp]    | key_q.up;
      dir_m[4*p+3] = joy_p[JoyDown]  | key_q.down;
      for (int k = 0; k < NUM_BUTTONS; k++) begin
        btn_m[NUM_BUTTONS*p+k] = joy_p[joy_btn(k)] | key_q.btn[k];
      end
      btn_m[NUM_BUTTONS*p] = btn_m[NUM_BUTTONS*p] & af_wave[p];
      start1_m = start1_m | joy_p[joy_start1(NUM_BUTTONS)];
      start2_m = start2_m | joy_p[joy_start2(NUM_BUTTONS)];
      coin1_m  = coin1_m  | joy_p[joy_coin1(NUM_BUTTONS)];
      pause_m  = pause_m  | joy_p[joy_pause(NUM_BUTTONS)];
    end
  end

  // Registered active-low game outputs and pause edge detection.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      dir_n        <= '1;
      btn_n        <= '1;
      start_n      <= '1;
      service_n    <= 1'b1;
      pause_prev_q <= 1'b0;
      pause_pulse  <= 1'b0;
    end else begin
      dir_n        <= ~dir_m;
      btn_n        <= ~btn_m;
      start_n      <= ~{start2_m, start1_m};
      service_n    <= ~key_q.service;
      pause_prev_q <= pause_m;
      pause_pulse  <= pause_m & ~pause_prev_q;
    end
  end

  coin_pulse_shaper #(
    .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)
  ) u_coin1 (
    .clk_49m(clk_49m),
    .reset  (reset),
    .coin   (coin1_m),
    .coin_n (coin_n[0])
  );

  coin_pulse_shaper #(
    .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES)
  ) u_coin2 (
    .clk_49m(clk_49m),
    .reset  (reset),
    .coin   (key_q.coin2),
    .coin_n (coin_n[1])
  );

  // DIP capture from ioctl index 254; out-of-range addresses match no bank.
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      bank_q <= '0;
    end else if (ioctl_wr && ioctl_index == 8'd254) begin
      for (int b = 0; b < NUM_DIP_BANKS; b++) begin
        if (ioctl_addr == 25'(b)) bank_q[b] <= ioctl_dout;
      end
    end
  end

  assign dipsw_n = ~bank_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench for arcade_input_ctrl with a spec-level reference model.
// Honours ARCADE_INPUT_AUTOFIRE_EN when defined for the whole build.
module tb_arcade_input_ctrl;
  localparam int NP = 2;
  localparam int NB = 2;
  localparam int ND = 3;
  localparam int NCOIN = 8;
  localparam int AFDIV = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [10:0]         ps2_key = '0;
  logic [16*NP-1:0]    joy_in = '0;
  logic                ioctl_wr = 1'b0;
  logic [7:0]          ioctl_index = '0;
  logic [24:0]         ioctl_addr = '0;
  logic [7:0]          ioctl_dout = '0;
  logic [4*NP-1:0]     dir_n;
  logic [NB*NP-1:0]    btn_n;
  logic [1:0]          start_n, coin_n;
  logic                service_n, pause_pulse;
  logic [8*ND-1:0]     dipsw_n;

  arcade_input_ctrl #(
    .NUM_PLAYERS(NP), .NUM_BUTTONS(NB), .NUM_DIP_BANKS(ND),
    .COIN_PULSE_CYCLES(NCOIN), .AUTOFIRE_DIV(AFDIV)
  ) dut (
    .clk_49m(clk), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .dir_n(dir_n), .btn_n(btn_n), .start_n(start_n),
    .coin_n(coin_n), .service_n(service_n), .pause_pulse(pause_pulse), .dipsw_n(dipsw_n)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: pressed flag per scancode, coin timers, pause history, DIP bytes.
  bit         key_st [256];
  bit         m_tog;
  int         m_left [2];
  bit         m_busy [2];
  bit         m_hold [2];
  bit         m_prev [2];
  bit         m_pz_prev;
  logic [7:0] m_dip [ND];
  logic [7:0] btn_code [4];

  logic [4*NP-1:0]  e_dir_n;
  logic [NB*NP-1:0] e_btn_n, af_mask;
  logic [1:0]       e_start_n, e_coin_n;
  logic             e_service_n, e_pause;
  logic [8*ND-1:0]  e_dip_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 256; i++) key_st[i] = 1'b0;
    m_tog = 1'b0;
    m_pz_prev = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_left[s] = 0; m_busy[s] = 1'b0; m_hold[s] = 1'b0; m_prev[s] = 1'b0;
    end
    for (int b = 0; b < ND; b++) m_dip[b] = 8'h00;
  endtask

  // Outputs after an edge follow the joystick at that edge and the key state before it.
  task automatic m_update();
    logic [15:0] j;
    logic [4*NP-1:0] d;
    logic [NB*NP-1:0] bt;
    bit s1, s2, c1, pz;
    bit cin [2];
    d = '0; bt = '0; af_mask = '0;
    s1 = key_st[8'h16]; s2 = key_st[8'h1E]; c1 = key_st[8'h2E]; pz = key_st[8'h4D];
    for (int p = 0; p < NP; p++) begin
      j = joy_in[16*p +: 16];
      d[4*p+0] = j[1] | key_st[8'h6B];
      d[4*p+1] = j[0] | key_st[8'h74];
      d[4*p+2] = j[3] | key_st[8'h75];
      d[4*p+3] = j[2] | key_st[8'h72];
      for (int k = 0; k < NB; k++) bt[NB*p+k] = j[4+k] | key_st[btn_code[k]];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      af_mask[NB*p] = j[15];
`endif
      s1 = s1 | j[4+NB]; c1 = c1 | j[5+NB]; s2 = s2 | j[6+NB]; pz = pz | j[7+NB];
    end
    e_dir_n = ~d; e_btn_n = ~bt; e_start_n = ~{s2, s1}; e_service_n = ~key_st[8'h46];
    e_pause = pz & ~m_pz_prev;
    m_pz_prev = pz;
    cin[0] = c1; cin[1] = key_st[8'h36];
    for (int s = 0; s < 2; s++) begin
      if (m_busy[s]) begin
        if (m_left[s] > 0) begin e_coin_n[s] = 1'b0; m_left[s]--; end
        else begin m_busy[s] = 1'b0; e_coin_n[s] = 1'b1; m_hold[s] = cin[s]; end
      end else if (m_hold[s]) begin
        e_coin_n[s] = 1'b1;
        if (!cin[s]) m_hold[s] = 1'b0;
      end else if (cin[s] && !m_prev[s]) begin
        m_busy[s] = 1'b1; m_left[s] = NCOIN - 1; e_coin_n[s] = 1'b0;
      end else begin
        e_coin_n[s] = 1'b1;
      end
      m_prev[s] = cin[s];
    end
    if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'(ND)) m_dip[ioctl_addr] = ioctl_dout;
    for (int b = 0; b < ND; b++) e_dip_n[8*b +: 8] = ~m_dip[b];
    if (ps2_key[10] != m_tog) key_st[ps2_key[7:0]] = ps2_key[9];
    m_tog = ps2_key[10];
  endtask

  task automatic m_compare();
    check("dir_n", 32'(dir_n), 32'(e_dir_n));
    check("btn_n", 32'(btn_n | af_mask), 32'(e_btn_n | af_mask));
    check("start_n", 32'(start_n), 32'(e_start_n));
    check("coin_n", 32'(coin_n), 32'(e_coin_n));
    check("service_n", 32'(service_n), 32'(e_service_n));
    check("pause_pulse", 32'(pause_pulse), 32'(e_pause));
    check("dipsw_n", 32'(dipsw_n), 32'(e_dip_n));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_update();
    @(negedge clk);
    if (reset) m_compare();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic key(input bit tog, input bit pressed, input logic [7:0] code);
    ps2_key = {tog, pressed, 1'b0, code};
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dir"}, 32'(dir_n), 32'hFF);
    check({tag, "_btn"}, 32'(btn_n), 32'hF);
    check({tag, "_start"}, 32'(start_n), 32'h3);
    check({tag, "_coin"}, 32'(coin_n), 32'h3);
    check({tag, "_service"}, 32'(service_n), 32'h1);
    check({tag, "_pause"}, 32'(pause_pulse), 32'h0);
    check({tag, "_dip"}, 32'(dipsw_n), 32'hFFFFFF);
  endtask

  initial begin
    int cnt;
    btn_code[0] = 8'h14; btn_code[1] = 8'h11; btn_code[2] = 8'h29; btn_code[3] = 8'h12;
    m_reset();
    // 1: reset state, then idle after release
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    ticks(3);

    // 2: keyboard up, two-cycle latency, reaches both players
    key(1'b1, 1'b1, 8'h75);
    tick(); check("up_lat1", 32'(dir_n), 32'hFF);
    tick(); check("up_lat2", 32'(dir_n), 32'hBB);
    ticks(2);
    key(1'b0, 1'b0, 8'h75);
    ticks(2); check("up_release", 32'(dir_n), 32'hFF);
    // coin2 via keyboard, held past the pulse
    key(1'b1, 1'b1, 8'h36); ticks(12);
    key(1'b0, 1'b0, 8'h36); ticks(4);
    // button 2 is beyond NUM_BUTTONS, unmapped code changes nothing
    key(1'b1, 1'b1, 8'h29); ticks(3); check("btn2_none", 32'(btn_n), 32'hF);
    key(1'b0, 1'b1, 8'h55); ticks(3); check("unmapped", 32'(btn_n), 32'hF);
    key(1'b1, 1'b1, 8'h14); ticks(2); check("kbd_btn0", 32'(btn_n), 32'hA);
    key(1'b0, 1'b0, 8'h14); ticks(2);
    key(1'b1, 1'b1, 8'h46); ticks(3);
    key(1'b0, 1'b0, 8'h46); ticks(2);
    key(1'b1, 1'b1, 8'h4D); ticks(4);
    key(1'b0, 1'b0, 8'h4D); ticks(2);
    // joystick mix: P1 right, P2 up, P2 btn1, P2 start2
    joy_in = '0;
    joy_in[0] = 1'b1; joy_in[19] = 1'b1; joy_in[21] = 1'b1; joy_in[24] = 1'b1;
    tick(); check("joy_dir", 32'(dir_n), 32'hBD);
    ticks(2);
    joy_in = '0; joy_in[25] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (pause_pulse) cnt++; end
    check("pause_once", 32'(cnt), 32'd1);
    joy_in = '0; ticks(3);

    // 3: held coin gives exactly one pulse; repress gives another
    joy_in[7] = 1'b1; cnt = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (!coin_n[0]) cnt++; end
    check("coin_len1", 32'(cnt), 32'd8);
    joy_in[7] = 1'b0; ticks(3);
    joy_in[7] = 1'b1; cnt = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (!coin_n[0]) cnt++; end
    check("coin_len2", 32'(cnt), 32'd8);
    joy_in[7] = 1'b0; ticks(3);

    // 4: short glitch still gives a full pulse; edge inside it does not extend
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      joy_in[7] = (i < 2) || (i == 3);
      tick(); if (!coin_n[0]) cnt++;
    end
    check("coin_glitch", 32'(cnt), 32'd8);
    joy_in[7] = 1'b0; ticks(2);

    // 5: DIP capture, ignored high address, async reset mid-pulse
    ioctl_index = 8'd254;
    for (int a = 0; a < 4; a++) begin
      logic [31:0] data_word;
      data_word = 32'hFF0F3CA5;
      ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = data_word[8*a +: 8];
      tick();
    end
    ioctl_wr = 1'b0;
    tick(); check("dip_banks", 32'(dipsw_n), 32'hF0C35A);
    joy_in[7] = 1'b1; ticks(3);
    #2 reset = 1'b0;
    #1 check_reset_values("midreset");
    m_reset();
    joy_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ticks(2);
    ioctl_wr = 1'b1; ioctl_addr = 25'd1; ioctl_dout = 8'h12;
    tick(); ioctl_wr = 1'b0;
    check("dip_after_reset", 32'(dipsw_n), 32'hFFEDFF);
    ticks(2);

    // 6: autofire on P2 button 0
    joy_in[31] = 1'b1; joy_in[20] = 1'b1;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    begin
      int run, trans;
      logic last;
      run = 0; trans = 0; last = 1'b1;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (i > 0 && btn_n[2] != last) begin
          if (trans > 0) check("af_run", 32'(run), 32'd4);
          trans++; run = 1;
        end else begin
          run++;
        end
        if (i == 0) check("af_first", 32'(btn_n[2]), 32'd0);
        last = btn_n[2];
      end
      check("af_trans", 32'(trans >= 4), 32'd1);
    end
`else
    for (int i = 0; i < 12; i++) begin
      tick(); check("af_off_b0", 32'(btn_n[2]), 32'd0);
    end
`endif
    joy_in = '0; ticks(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
